subsat_phrase: RTL

Sequential saturating-subtract unit for the Tom blitter/GPU pixel datapath. It is the decrement counterpart of the saturating 16-bit add array. It accepts one 64-bit phrase of unsigned pixel/intensity data plus a 64-bit phrase of signed deltas. It processes the phrase as four 16-bit lanes, one lane per clock, through a single shared lane subtractor, then holds the result phrase until the consumer takes it.

---
 rtl/subsat_phrase_pkg.sv | 27 ++
 rtl/subsat_phrase_if.sv | 39 +++
 rtl/subsat_phrase_sub16sat.sv | 59 +++++
 rtl/subsat_phrase.sv | 112 +++++++++++
 4 files changed

// File: rtl/subsat_phrase_pkg.sv
// ----------------------------------------------------------------------------
// subsat_phrase_pkg
// Shared constants for the phrase saturating-subtract unit: lane geometry,
// lane counter width, FSM state encodings and a lane-slice helper.
// Optional feature macro used by the other files: SUBSAT_STATUS_EN.
// ----------------------------------------------------------------------------
package subsat_phrase_pkg;

    localparam int LANES   = 4;
    localparam int LANEW   = 16;
    localparam int PHRASEW = LANES * LANEW;
    localparam int CNTW    = $clog2(LANES);

    localparam logic [CNTW-1:0] LAST_LANE = CNTW'(LANES - 1);

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Lane k occupies bits [16k+15:16k] of a phrase; bit 0 is the LSB.
    function automatic logic [LANEW-1:0] lane_of(input logic [PHRASEW-1:0] phrase,
                                                 input logic [CNTW-1:0]    idx);
        return phrase[int'(idx) * LANEW +: LANEW];
    endfunction

endpackage

// File: rtl/subsat_phrase_if.sv
// ----------------------------------------------------------------------------
// subsat_phrase_if
// Operand/result handshake bundle for subsat_phrase.
//   in_valid/in_ready   : operand phrase handshake
//   a, b                : unsigned minuend phrase, signed subtrahend phrase
//   sat/eightbit/hicinh : mode bits, sampled at accept
//   out_valid/out_ready : result handshake
//   r                   : result phrase
//   sat_flags           : per-lane clamp flags (only with SUBSAT_STATUS_EN)
// Modports: master = producer/consumer side, slave = the unit.
// ----------------------------------------------------------------------------
interface subsat_phrase_if;
    import subsat_phrase_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [PHRASEW-1:0] a;
    logic [PHRASEW-1:0] b;
    logic               sat;
    logic               eightbit;
    logic               hicinh;
    logic               out_valid;
    logic               out_ready;
    logic [PHRASEW-1:0] r;
`ifdef SUBSAT_STATUS_EN
    logic [LANES-1:0]   sat_flags;

    modport master (output in_valid, a, b, sat, eightbit, hicinh, out_ready,
                    input  in_ready, out_valid, r, sat_flags);
    modport slave  (input  in_valid, a, b, sat, eightbit, hicinh, out_ready,
                    output in_ready, out_valid, r, sat_flags);
`else
    modport master (output in_valid, a, b, sat, eightbit, hicinh, out_ready,
                    input  in_ready, out_valid, r);
    modport slave  (input  in_valid, a, b, sat, eightbit, hicinh, out_ready,
                    output in_ready, out_valid, r);
`endif

endinterface

// File: rtl/subsat_phrase_sub16sat.sv
// ----------------------------------------------------------------------------
// sub16sat
// Combinational 16-bit lane subtractor r = a - b (as a + ~b + 1) with a
// segmented carry chain and optional saturation.
//   a        in  unsigned minuend lane
//   b        in  signed subtrahend lane
//   sat      in  enable clamping
//   eightbit in  low byte is an independent 8-bit value; high byte wraps
//   hicinh   in  no borrow from bit 11 into bit 12
//   r        out lane result
//   clamp    out lane result was clamped
// ----------------------------------------------------------------------------
module sub16sat
    import subsat_phrase_pkg::*;
(
    input  logic [LANEW-1:0] a,
    input  logic [LANEW-1:0] b,
    input  logic             sat,
    input  logic             eightbit,
    input  logic             hicinh,
    output logic [LANEW-1:0] r,
    output logic             clamp
);

    // The chain is split at bit 8 and bit 12 so each break point can force
    // its carry-in to 1 (i.e. no borrow crosses the boundary).
    logic [8:0]       lo_sum;
    logic [4:0]       mid_sum;
    logic [4:0]       hi_sum;
    logic             cin8;
    logic             cin12;
    logic             btop;
    logic             ctop;
    logic [LANEW-1:0] diff;

    assign lo_sum  = {1'b0, a[7:0]}   + {1'b0, ~b[7:0]}   + 9'd1;
    assign cin8    = eightbit | lo_sum[8];
    assign mid_sum = {1'b0, a[11:8]}  + {1'b0, ~b[11:8]}  + {4'd0, cin8};
    assign cin12   = hicinh | mid_sum[4];
    assign hi_sum  = {1'b0, a[15:12]} + {1'b0, ~b[15:12]} + {4'd0, cin12};
    assign diff    = {hi_sum[3:0], mid_sum[3:0], lo_sum[7:0]};

    // Positive b with no carry out is an underflow; negative b with a carry
    // out is an overflow. Either way the clamp value is the carry itself.
    assign btop  = eightbit ? b[7]      : b[15];
    assign ctop  = eightbit ? lo_sum[8] : hi_sum[4];
    assign clamp = sat & ~(btop ^ ctop);

    // NOTE: r gets a full default before any conditional override, so no
    // path through this block leaves it unassigned and no latch is inferred.
    always_comb begin
        r = diff;
        if (clamp) begin
            if (eightbit) r[7:0] = {8{ctop}};
            else          r      = {LANEW{ctop}};
        end
    end

endmodule

// File: rtl/subsat_phrase.sv
// ----------------------------------------------------------------------------
// subsat_phrase
// Sequential saturating-subtract unit: accepts a 64-bit phrase, runs its four
// 16-bit lanes one per clock through a single shared sub16sat, then holds the
// result until the consumer takes it.
//   sys_clk  in  system clock
//   reset    in  synchronous active-high reset
//   bus      slave side of subsat_phrase_if (handshakes, operands, modes,
//            result, optional sat_flags)
// Optional feature: define SUBSAT_STATUS_EN to add per-lane clamp flags.
// ----------------------------------------------------------------------------
module subsat_phrase (
    input  logic            sys_clk,
    input  logic            reset,
    subsat_phrase_if.slave  bus
);
    import subsat_phrase_pkg::*;

    logic [1:0]         state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [PHRASEW-1:0] r_q, r_d;
    logic [PHRASEW-1:0] a_q, b_q;
    logic               sat_q, eightbit_q, hicinh_q;
    logic               accept;
    logic [LANEW-1:0]   lane_r;
    logic               lane_clamp;

    assign bus.in_ready  = (state_q == ST_IDLE) & ~reset;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.r         = r_q;
    assign accept        = bus.in_ready & bus.in_valid;

    sub16sat u_lane (
        .a        (lane_of(a_q, cnt_q)),
        .b        (lane_of(b_q, cnt_q)),
        .sat      (sat_q),
        .eightbit (eightbit_q),
        .hicinh   (hicinh_q),
        .r        (lane_r),
        .clamp    (lane_clamp)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                r_d[int'(cnt_q) * LANEW +: LANEW] = lane_r;
                if (cnt_q == LAST_LANE) state_d = ST_DONE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
        end
    end

    // NOTE: the operand/mode holding registers carry no reset; they are
    // always loaded at accept before anything reads them.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            sat_q      <= bus.sat;
            eightbit_q <= bus.eightbit;
            hicinh_q   <= bus.hicinh;
        end
    end

`ifdef SUBSAT_STATUS_EN
    logic [LANES-1:0] flags_q, flags_d;

    always_comb begin
        flags_d = flags_q;
        if (accept)                  flags_d        = '0;
        else if (state_q == ST_RUN)  flags_d[cnt_q] = lane_clamp;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) flags_q <= '0;
        else       flags_q <= flags_d;
    end

    assign bus.sat_flags = flags_q;
`else
    logic lane_clamp_unused;
    assign lane_clamp_unused = lane_clamp;
`endif

endmodule
